pll_phase_ctrl: RTL and testbench
=================================

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

Interface
REQ-001 Parameter: NUM_CLOCKS, 3, number of PLL output counters C0..C(NUM_CLOCKS-1) under control; legal range 1..5.
REQ-002 Parameter: STEP_W, 8, width of signed step request and per-channel offset accumulator.
REQ-003 Parameter: PULSE_CYCLES, 2, phasestep high time in clk cycles; minimum 2.
REQ-004 Parameter: TIMEOUT_CYCLES, 1023, maximum clk cycles spent waiting on any phasedone edge.
REQ-005 clk  in  1  single clock; also drives the PLL scanclk.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 pll_locked  in  1  PLL lock indicator.
REQ-008 req_valid / req_ready  in / out  1 / 1  request handshake; a request transfers when both are high on a rising clk edge.
REQ-009 req_chan  in  3  target counter index, 0..NUM_CLOCKS-1.
REQ-010 req_steps  in  STEP_W  signed step count; positive = phase later (phaseupdown=1), negative = earlier.
REQ-011 phasecounterselect  out  3  PLL counter select; channel k encodes as k+2.
REQ-012 phaseupdown / phasestep  out / out  1 / 1  PLL dynamic phase controls.
REQ-013 phasedone  in  1  PLL phase-step completion, active high.
REQ-014 busy / done / error  out / out / out  1 / 1 / 1  busy level; one-cycle done pulse; one-cycle error pulse.
REQ-015 phase_offset  out  NUM_CLOCKS*STEP_W  signed accumulated steps per channel, channel k at bits [k*STEP_W +: STEP_W].

Function
REQ-016 FSM states SHALL be IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI, NEXT.
REQ-017 req_ready SHALL equal (state==IDLE && pll_locked).
REQ-018 On accept: latch chan, |steps|, direction; go to SETUP; busy=1 from the next cycle until return to IDLE.
REQ-019 Accepted request with req_chan>=NUM_CLOCKS, or whose final offset would exceed the signed STEP_W range: error pulse next cycle, no phasestep, offsets unchanged, remain IDLE.
REQ-020 Accepted request with req_steps==0: done pulse next cycle, no phasestep, remain IDLE.
REQ-021 SETUP (1 cycle): drive phasecounterselect and phaseupdown; both SHALL stay stable until leaving WAIT_HI.
REQ-022 PULSE: phasestep=1 for exactly PULSE_CYCLES cycles, then WAIT_LO.
REQ-023 WAIT_LO: advance to WAIT_HI when phasedone==0; WAIT_HI: advance to NEXT when phasedone==1.
REQ-024 NEXT (1 cycle): phase_offset[chan] += ±1, remaining -= 1; remaining==0 -> done pulse, IDLE; else SETUP.
REQ-025 Timeout counter SHALL clear on entering WAIT_LO and WAIT_HI; reaching TIMEOUT_CYCLES in either -> error pulse, IDLE, step not counted.
REQ-026 pll_locked==0 in any non-IDLE state: abort next cycle, phasestep=0, error pulse, IDLE; offsets retain steps completed so far.
REQ-027 done and error SHALL never assert in the same cycle.
REQ-028 req_valid asserted while busy SHALL be ignored, not queued.

Reset
REQ-029 With reset_n==0 at a clk edge: state=IDLE, phasestep=0, phaseupdown=0, phasecounterselect=0, busy=0, done=0, error=0, all phase_offset=0, counters cleared.
REQ-030 Reset asserted mid-operation SHALL take effect at the next edge; phasestep falls at that edge regardless of PLL state.

Verification
REQ-031 Locked PLL model (phasedone low 3 cycles after phasestep falls, high 4 cycles later); request chan=1, steps=+3 -> three phasestep pulses of 2 cycles, phasecounterselect=3, phaseupdown=1, done once, offset[1]=+3.
REQ-032 Request chan=0, steps=-2 after offset[0]=+1 -> phaseupdown=0, offset[0]=-1, done pulse.
REQ-033 Request chan=5 (NUM_CLOCKS=3), then offset at +127 with steps=+1 -> error pulse each, no phasestep, offsets unchanged.
REQ-034 Model holds phasedone high forever -> error after TIMEOUT_CYCLES in WAIT_LO, offset unchanged, req_ready=1 next cycle.
REQ-035 Drop pll_locked during step 2 of steps=+4 -> error pulse, phasestep=0, offset=+1, req_ready=0 until pll_locked=1.
REQ-036 reset_n low during PULSE -> next cycle phasestep=0, busy=0, all offsets 0.

Source files
------------

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: sequences PLL dynamic phase steps (phasestep/phasedone handshake)
// and tracks the signed accumulated offset of each output counter.
module pll_phase_ctrl #(
  parameter int NUM_CLOCKS     = 3,
  parameter int STEP_W         = 8,
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_pll_locked,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [2:0]                   i_req_chan,
  input  logic signed [STEP_W-1:0]     i_req_steps,
  output logic [2:0]                   o_phasecounterselect,
  output logic                         o_phaseupdown,
  output logic                         o_phasestep,
  input  logic                         i_phasedone,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [NUM_CLOCKS*STEP_W-1:0] o_phase_offset
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + PULSE_CYCLES + 1);
  localparam logic [2:0] NC = 3'(NUM_CLOCKS);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] PMAX = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI, NEXT} state_t;

  state_t            r_state;
  logic [2:0]        r_chan;
  logic [STEP_W-1:0] r_rem;
  logic              r_dir;
  logic [CW-1:0]     r_cnt;
  logic [STEP_W-1:0] r_off [NUM_CLOCKS];
  logic [2:0]        r_sel;
  logic              r_updown;
  logic              r_step;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_acc;
  logic              w_bad;
  logic [STEP_W-1:0] w_cur;
  logic [STEP_W:0]   w_sum;
  logic [STEP_W-1:0] w_abs;

  assign o_req_ready          = r_state == IDLE && i_pll_locked;
  assign o_phasecounterselect = r_sel;
  assign o_phaseupdown        = r_updown;
  assign o_phasestep          = r_step;
  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_error              = r_err;

  genvar g;
  for (g = 0; g < NUM_CLOCKS; g++) begin : g_off
    assign o_phase_offset[g*STEP_W +: STEP_W] = r_off[g];
  end

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < NUM_CLOCKS; k++)
      if (i_req_chan == 3'(k)) w_cur = r_off[k];
  end

  // one extra bit exposes signed overflow of the final offset
  assign w_sum = {w_cur[STEP_W-1], w_cur} + {i_req_steps[STEP_W-1], i_req_steps};
  assign w_bad = i_req_chan >= NC || w_sum[STEP_W] != w_sum[STEP_W-1];
  assign w_abs = i_req_steps[STEP_W-1] ? STEP_W'(-i_req_steps) : i_req_steps;
  assign w_acc = i_req_valid && o_req_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_chan   <= '0;
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_updown <= 1'b0;
      r_step   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      for (int k = 0; k < NUM_CLOCKS; k++) r_off[k] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state != IDLE && !i_pll_locked) begin
        r_state <= IDLE;
        r_step  <= 1'b0;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        case (r_state)
          IDLE:
            if (w_acc) begin
              if (w_bad) r_err <= 1'b1;
              else if (i_req_steps == '0) r_done <= 1'b1;
              else begin
                r_state  <= SETUP;
                r_busy   <= 1'b1;
                r_chan   <= i_req_chan;
                r_rem    <= w_abs;
                r_dir    <= ~i_req_steps[STEP_W-1];
                r_sel    <= i_req_chan + 3'd2;
                r_updown <= ~i_req_steps[STEP_W-1];
              end
            end
          SETUP: begin
            r_state <= PULSE;
            r_step  <= 1'b1;
            r_cnt   <= '0;
          end
          PULSE:
            if (r_cnt == PMAX) begin
              r_state <= WAIT_LO;
              r_step  <= 1'b0;
              r_cnt   <= '0;
            end else r_cnt <= r_cnt + C1;
          WAIT_LO:
            if (!i_phasedone) begin
              r_state <= WAIT_HI;
              r_cnt   <= '0;
            end else if (r_cnt == TMAX) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else r_cnt <= r_cnt + C1;
          WAIT_HI:
            if (i_phasedone) r_state <= NEXT;
            else if (r_cnt == TMAX) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else r_cnt <= r_cnt + C1;
          NEXT: begin
            for (int k = 0; k < NUM_CLOCKS; k++)
              if (r_chan == 3'(k)) r_off[k] <= r_dir ? r_off[k] + ONE : r_off[k] - ONE;
            r_rem <= r_rem - ONE;
            if (r_rem == ONE) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else r_state <= SETUP;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb_pll_phase_ctrl: vector table, directed corner sequences and random requests
// against a per-request offset model with a behavioural PLL responder.
module tb_pll_phase_ctrl;
  logic        clk = 1'b0;
  logic        i_reset_n, i_pll_locked, i_req_valid, i_phasedone;
  logic [2:0]  i_req_chan;
  logic signed [7:0] i_req_steps;
  logic        o_req_ready, o_phaseupdown, o_phasestep, o_busy, o_done, o_error;
  logic [2:0]  o_phasecounterselect;
  logic [23:0] o_phase_offset;

  always #5 clk = ~clk;

  pll_phase_ctrl dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_pll_locked(i_pll_locked),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_chan(i_req_chan),
    .i_req_steps(i_req_steps), .o_phasecounterselect(o_phasecounterselect),
    .o_phaseupdown(o_phaseupdown), .o_phasestep(o_phasestep), .i_phasedone(i_phasedone),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_phase_offset(o_phase_offset)
  );

  typedef struct {
    int chan; int steps; bit e_done; bit e_err; int e_pulses; logic [23:0] e_off;
  } vec_t;
  vec_t tbl [11];

  int checks = 0, errors = 0;
  int m_off [3];
  bit hang = 1'b0;
  logic [2:0] exp_sel = 3'd0;
  logic exp_ud = 1'b0;
  int dones = 0, errs = 0, pulses = 0, len_bad = 0, sel_bad = 0, ud_bad = 0, both = 0, cur_len = 0;

  // PLL responder: phasedone low 3 cycles after phasestep falls, high 4 cycles later
  initial begin
    i_phasedone = 1'b1;
    forever begin
      @(negedge o_phasestep);
      if (!hang) begin
        repeat (3) @(negedge clk);
        i_phasedone = 1'b0;
        repeat (4) @(negedge clk);
        i_phasedone = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (o_phasestep === 1'b1) begin
      cur_len++;
      if (o_phasecounterselect !== exp_sel) sel_bad++;
      if (o_phaseupdown !== exp_ud) ud_bad++;
    end else if (cur_len != 0) begin
      pulses++;
      if (cur_len != 2) len_bad++;
      cur_len = 0;
    end
    if (o_done === 1'b1) dones++;
    if (o_error === 1'b1) errs++;
    if (o_done === 1'b1 && o_error === 1'b1) both++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pack_model();
    return {8'(m_off[2]), 8'(m_off[1]), 8'(m_off[0])};
  endfunction

  task automatic do_req(input int c, input int s, input bit ed, input bit ee, input int ep,
                        input logic [23:0] eo, input string nm, output int n);
    int b_d, b_e, b_p, b_l, b_s, b_u, b_b;
    exp_sel = 3'(c + 2);
    exp_ud  = s > 0;
    b_d = dones; b_e = errs; b_p = pulses; b_l = len_bad; b_s = sel_bad; b_u = ud_bad; b_b = both;
    i_req_chan  = 3'(c);
    i_req_steps = 8'(s);
    i_req_valid = 1'b1;
    chk({nm, " ready"}, 32'(o_req_ready), 1);
    tick;
    i_req_valid = 1'b0;
    if (ep == 0) begin
      chk({nm, " done next"}, 32'(o_done), 32'(ed));
      chk({nm, " error next"}, 32'(o_error), 32'(ee));
      chk({nm, " busy idle"}, 32'(o_busy), 0);
    end else chk({nm, " busy"}, 32'(o_busy), 1);
    n = 0;
    while (n < 3000 && dones == b_d && errs == b_e) begin
      tick;
      n++;
    end
    chk({nm, " finished"}, 32'(n < 3000), 1);
    repeat (3) tick;
    chk({nm, " dones"}, dones - b_d, 32'(ed));
    chk({nm, " errors"}, errs - b_e, 32'(ee));
    chk({nm, " pulses"}, pulses - b_p, ep);
    chk({nm, " pulse len"}, len_bad - b_l, 0);
    chk({nm, " select"}, sel_bad - b_s, 0);
    chk({nm, " updown"}, ud_bad - b_u, 0);
    chk({nm, " done&error"}, both - b_b, 0);
    chk({nm, " offset"}, 32'(o_phase_offset), 32'(eo));
    chk({nm, " busy end"}, 32'(o_busy), 0);
    chk({nm, " ready end"}, 32'(o_req_ready), 1);
  endtask

  initial begin
    int n, c, s, cur, b_d, b_p;
    bit bad, ok;
    tbl[0]  = '{1,    3, 1, 0,   3, 24'h000300};
    tbl[1]  = '{0,    1, 1, 0,   1, 24'h000301};
    tbl[2]  = '{0,   -2, 1, 0,   2, 24'h0003FF};
    tbl[3]  = '{5,    1, 0, 1,   0, 24'h0003FF};
    tbl[4]  = '{2,    0, 1, 0,   0, 24'h0003FF};
    tbl[5]  = '{7,    0, 0, 1,   0, 24'h0003FF};
    tbl[6]  = '{2,  127, 1, 0, 127, 24'h7F03FF};
    tbl[7]  = '{2,    1, 0, 1,   0, 24'h7F03FF};
    tbl[8]  = '{2, -128, 1, 0, 128, 24'hFF03FF};
    tbl[9]  = '{0, -127, 1, 0, 127, 24'hFF0380};
    tbl[10] = '{0,   -1, 0, 1,   0, 24'hFF0380};
    i_reset_n = 1'b0; i_pll_locked = 1'b1; i_req_valid = 1'b0;
    i_req_chan = 3'd0; i_req_steps = 8'sd0;
    repeat (3) tick;
    chk("rst phasestep", 32'(o_phasestep), 0);
    chk("rst updown", 32'(o_phaseupdown), 0);
    chk("rst select", 32'(o_phasecounterselect), 0);
    chk("rst busy", 32'(o_busy), 0);
    chk("rst done", 32'(o_done), 0);
    chk("rst error", 32'(o_error), 0);
    chk("rst offset", 32'(o_phase_offset), 0);
    chk("rst ready", 32'(o_req_ready), 1);
    i_reset_n = 1'b1;
    tick;
    foreach (tbl[i])
      do_req(tbl[i].chan, tbl[i].steps, tbl[i].e_done, tbl[i].e_err, tbl[i].e_pulses,
             tbl[i].e_off, $sformatf("vec%0d", i), n);

    hang = 1'b1;
    do_req(1, 1, 0, 1, 1, 24'hFF0380, "timeout", n);
    chk("timeout latency", 32'(n >= 1023 && n <= 1032), 1);
    hang = 1'b0;

    exp_sel = 3'd2; exp_ud = 1'b1;
    i_req_chan = 3'd0; i_req_steps = 8'sd2; i_req_valid = 1'b1;
    tick;
    i_req_valid = 1'b0;
    n = 0;
    while (n < 20 && o_phasestep !== 1'b1) begin tick; n++; end
    chk("rst-pulse reached", 32'(n < 20), 1);
    i_reset_n = 1'b0;
    tick;
    chk("rst-pulse phasestep", 32'(o_phasestep), 0);
    chk("rst-pulse busy", 32'(o_busy), 0);
    chk("rst-pulse offset", 32'(o_phase_offset), 0);
    chk("rst-pulse error", 32'(o_error), 0);
    i_reset_n = 1'b1;
    repeat (12) tick;
    m_off = '{0, 0, 0};

    exp_sel = 3'd3; exp_ud = 1'b1;
    b_d = dones; b_p = pulses;
    i_req_chan = 3'd1; i_req_steps = 8'sd4; i_req_valid = 1'b1;
    tick;
    i_req_valid = 1'b0;
    n = 0;
    while (n < 100 && !(o_phasestep === 1'b1 && pulses - b_p == 1)) begin tick; n++; end
    chk("unlock reached step2", 32'(n < 100), 1);
    i_pll_locked = 1'b0;
    tick;
    chk("unlock error", 32'(o_error), 1);
    chk("unlock done", 32'(o_done), 0);
    chk("unlock phasestep", 32'(o_phasestep), 0);
    chk("unlock busy", 32'(o_busy), 0);
    chk("unlock ready", 32'(o_req_ready), 0);
    chk("unlock offset", 32'(o_phase_offset), 32'h000100);
    repeat (3) tick;
    chk("unlock ready held", 32'(o_req_ready), 0);
    chk("unlock error pulse", 32'(o_error), 0);
    i_pll_locked = 1'b1;
    #1;
    chk("relock ready", 32'(o_req_ready), 1);
    chk("unlock no done", dones - b_d, 0);
    repeat (12) tick;
    m_off[1] = 1;

    for (int r = 0; r < 40; r++) begin
      c = int'($urandom_range(0, 3));
      s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) - 128
                                       : int'($urandom_range(0, 12)) - 6;
      cur = 0;
      if (c < 3) cur = m_off[c];
      bad = c >= 3 || cur + s > 127 || cur + s < -128;
      ok = !bad;
      if (ok) m_off[c] = cur + s;
      do_req(c, s, ok, bad, bad ? 0 : (s < 0 ? -s : s), pack_model(), $sformatf("rand%0d", r), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
